// File: rtl/demux_1_2_stream_pkg.sv
// Shared types for the 1:2 stream demultiplexer.
// The route select is named here so the top level reads in terms of
// destination ports rather than raw bit values.
package demux_1_2_stream_pkg;

  // Destination of an incoming word, encoded exactly as the in_sel pin.
  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } route_sel_e;

  // Map the raw select pin onto the route enum.
  function automatic route_sel_e to_route(input logic sel);
    return route_sel_e'(sel);
  endfunction

endpackage : demux_1_2_stream_pkg

// File: rtl/demux_out_buffer.sv
// Two-entry output FIFO for one leg of the 1:2 stream demultiplexer.
// Holds the head word in head_q and the second word in tail_q, and tracks
// occupancy (0..2) in a registered counter. 'space' depends only on the
// registered occupancy, so the upstream ready path never sees the
// consumer's ready. Also counts words popped since reset, with silent wrap.
module demux_out_buffer
  import demux_1_2_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             space,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  localparam int               OCC_W   = 2;
  localparam logic [OCC_W-1:0] OCC_MAX = 2'd2;

  logic [OCC_W-1:0] occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop;

  assign space   = (occ_q < OCC_MAX);
  assign valid   = (occ_q != '0);
  assign data    = head_q;
  assign count   = count_q;

  // A push into a full buffer is ignored; the top never issues one.
  assign push_ok = push & space;
  assign pop     = valid & ready;

  // Next-state for occupancy, storage and the pop counter.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    occ_d   = occ_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    unique case ({push_ok, pop})
      2'b10: begin
        // Push only: fill the first free slot.
        if (occ_q == '0) head_d = push_data;
        else             tail_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        // Pop only: the second entry (if any) moves up to the head.
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Push and pop together only happen at occupancy 1 (push needs
        // space, pop needs a head), so the new word replaces the head.
        head_d = push_data;
      end
      default: ;
    endcase

    if (pop) count_d = count_q + 1'b1;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two data slots are cleared on reset only because the
      // head is visible on the data output, which must read zero after
      // reset; pure storage behind a valid flag would not need it.
      occ_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule : demux_out_buffer

// File: rtl/demux_1_2_stream.sv
// 1:2 stream demultiplexer: one valid/ready input routed by in_sel to one of
// two valid/ready outputs, each decoupled by a two-entry buffer.
// in_ready reflects only the selected buffer's registered space, so a full
// buffer on one side never stalls words heading for the other side.
module demux_1_2_stream
  import demux_1_2_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  route_sel_e route;
  logic       a_space;
  logic       b_space;
  logic       accept;
  logic       push_a;
  logic       push_b;

  assign route    = to_route(in_sel);
  assign in_ready = (route == SEL_B) ? b_space : a_space;
  assign accept   = in_valid & in_ready;
  assign push_a   = accept & (route == SEL_A);
  assign push_b   = accept & (route == SEL_B);

  demux_out_buffer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_buf_a (
    .clk       (clk),
    .rst       (rst),
    .push      (push_a),
    .push_data (in_data),
    .space     (a_space),
    .valid     (a_valid),
    .ready     (a_ready),
    .data      (a_data),
    .count     (a_count)
  );

  demux_out_buffer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_buf_b (
    .clk       (clk),
    .rst       (rst),
    .push      (push_b),
    .push_data (in_data),
    .space     (b_space),
    .valid     (b_valid),
    .ready     (b_ready),
    .data      (b_data),
    .count     (b_count)
  );

endmodule : demux_1_2_stream

// File: tb/tb_demux_1_2_stream.sv
// Bench for demux_1_2_stream: queue-based reference model compared against
// the DUT on every falling edge, directed scenarios with literal
// expectations, then a randomized soak with occasional resets.
module tb_demux_1_2_stream;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  demux_1_2_stream #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr    = 0;

  // Reference model: one queue per port, pop counters, valid after first reset.
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  int               ca = 0;
  int               cb = 0;
  bit               live = 1'b0;
  bit               m_pop_a, m_pop_b, m_acc;

  // Words seen leaving each port, for the directed scenarios.
  logic [WIDTH-1:0] loga[$];
  logic [WIDTH-1:0] logb[$];

  logic r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; rdy is in_ready sampled mid-cycle.
  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                       input logic ar, input logic br, output logic rdy);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
    #1 rdy = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ar, input logic br);
    logic dummy;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, ar, br, dummy);
  endtask

  // Model update at each rising edge from the inputs held across it.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        qa   = {};
        qb   = {};
        ca   = 0;
        cb   = 0;
        live = 1'b1;
      end else if (live) begin
        m_acc   = in_valid && (in_sel ? (qb.size() < 2) : (qa.size() < 2));
        m_pop_a = (qa.size() > 0) && a_ready;
        m_pop_b = (qb.size() > 0) && b_ready;
        if (m_pop_a) begin
          void'(qa.pop_front());
          ca = (ca + 1) % CNT_MOD;
        end
        if (m_pop_b) begin
          void'(qb.pop_front());
          cb = (cb + 1) % CNT_MOD;
        end
        if (m_acc) begin
          if (in_sel) qb.push_back(in_data);
          else        qa.push_back(in_data);
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        check("in_ready", {31'b0, in_ready}, {31'b0, (in_sel ? (qb.size() < 2) : (qa.size() < 2))});
        check("a_valid", {31'b0, a_valid}, {31'b0, (qa.size() > 0)});
        check("b_valid", {31'b0, b_valid}, {31'b0, (qb.size() > 0)});
        if (qa.size() > 0) check("a_data", 32'(a_data), 32'(qa[0]));
        if (qb.size() > 0) check("b_data", 32'(b_data), 32'(qb[0]));
        check("a_count", 32'(a_count), ca);
        check("b_count", 32'(b_count), cb);
        if (!rst && a_valid && a_ready) loga.push_back(a_data);
        if (!rst && b_valid && b_ready) logb.push_back(b_data);
      end
    end
  end

  initial begin
    in_valid = 1'b0;
    in_sel   = 1'b0;
    in_data  = '0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;

    // Reset held two cycles with a word offered.
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, r);
    drive(1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, r);
    rst = 1'b0;
    check("rst_a_valid", {31'b0, a_valid}, 32'd0);
    check("rst_b_valid", {31'b0, b_valid}, 32'd0);
    check("rst_a_data", 32'(a_data), 32'd0);
    check("rst_b_data", 32'(b_data), 32'd0);
    check("rst_a_count", 32'(a_count), 32'd0);
    check("rst_b_count", 32'(b_count), 32'd0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, r);
    check("rst_in_ready", {31'b0, r}, 32'd1);

    // Routing with both consumers ready.
    loga = {};
    logb = {};
    drive(1'b1, 1'b0, 8'h11, 1'b1, 1'b1, r);
    check("route_acc_11", {31'b0, r}, 32'd1);
    check("route_lat_a_valid", {31'b0, a_valid}, 32'd1);
    check("route_lat_a_data", 32'(a_data), 32'h11);
    drive(1'b1, 1'b1, 8'h22, 1'b1, 1'b1, r);
    check("route_lat_b_valid", {31'b0, b_valid}, 32'd1);
    check("route_lat_b_data", 32'(b_data), 32'h22);
    drive(1'b1, 1'b0, 8'h33, 1'b1, 1'b1, r);
    check("route_lat_a_data2", 32'(a_data), 32'h33);
    idle(3, 1'b1, 1'b1);
    check("route_a_n", loga.size(), 32'd2);
    check("route_a0", 32'(loga[0]), 32'h11);
    check("route_a1", 32'(loga[1]), 32'h33);
    check("route_b_n", logb.size(), 32'd1);
    check("route_b0", 32'(logb[0]), 32'h22);
    check("route_a_count", 32'(a_count), 32'd2);
    check("route_b_count", 32'(b_count), 32'd1);

    // Backpressure on A; B stays reachable.
    loga = {};
    logb = {};
    drive(1'b1, 1'b0, 8'hA1, 1'b0, 1'b1, r);
    check("bp_acc_a1", {31'b0, r}, 32'd1);
    drive(1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, r);
    check("bp_acc_a2", {31'b0, r}, 32'd1);
    drive(1'b1, 1'b0, 8'hA3, 1'b0, 1'b1, r);
    check("bp_rej_a3", {31'b0, r}, 32'd0);
    check("bp_head_stable", 32'(a_data), 32'hA1);
    drive(1'b1, 1'b1, 8'hB1, 1'b0, 1'b1, r);
    check("bp_b_accepts", {31'b0, r}, 32'd1);

    // Full buffer with a_ready: pop only, push accepted next cycle.
    drive(1'b1, 1'b0, 8'hA3, 1'b1, 1'b1, r);
    check("full_pop_only", {31'b0, r}, 32'd0);
    drive(1'b1, 1'b0, 8'hA3, 1'b1, 1'b1, r);
    check("full_push_next", {31'b0, r}, 32'd1);
    idle(4, 1'b1, 1'b1);
    check("bp_a_n", loga.size(), 32'd3);
    check("bp_a0", 32'(loga[0]), 32'hA1);
    check("bp_a1", 32'(loga[1]), 32'hA2);
    check("bp_a2", 32'(loga[2]), 32'hA3);
    check("bp_b0", 32'(logb[0]), 32'hB1);
    check("bp_a_count", 32'(a_count), 32'd5);
    check("bp_b_count", 32'(b_count), 32'd2);

    // Mid-operation reset discards buffered words.
    drive(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0, r);
    drive(1'b1, 1'b0, 8'hC2, 1'b0, 1'b0, r);
    check("mid_a_full", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, r);
    rst = 1'b0;
    check("mid_a_valid", {31'b0, a_valid}, 32'd0);
    check("mid_a_count", 32'(a_count), 32'd0);
    loga = {};
    idle(3, 1'b1, 1'b1);
    check("mid_no_stale", loga.size(), 32'd0);

    // Counter wrap: 17 pops on B with a 4-bit counter.
    logb = {};
    for (int i = 0; i < 17; i++) drive(1'b1, 1'b1, 8'(i + 1), 1'b0, 1'b1, r);
    idle(2, 1'b0, 1'b1);
    check("wrap_b_n", logb.size(), 32'd17);
    check("wrap_b_last", 32'(logb[16]), 32'd17);
    check("wrap_b_count", 32'(b_count), 32'd1);

    // Randomized soak: light then heavy backpressure, rare resets.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (i < 2000)
        drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, r);
      else
        drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom),
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, r);
    end
    rst = 1'b0;
    idle(4, 1'b1, 1'b1);
    check("drain_a_empty", {31'b0, a_valid}, 32'd0);
    check("drain_b_empty", {31'b0, b_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule : tb_demux_1_2_stream
